core_loader: RTL

- Host-side sequencer for the single-cycle core.
- Takes a 32-bit command/data word stream and writes programs into the core's instruction memory write port and data memory port-B.
- Controls the core's run and reset inputs, optionally stopping the core after a cycle budget.
- Sits between the host link (e.g. a UART word assembler) and core.

---
 rtl/core_loader_pkg.sv | 26 ++
 rtl/core_loader_run_timer.sv | 63 ++++++
 rtl/core_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/core_loader_pkg.sv
// Shared definitions for the core loader: command opcodes, opcode field position
// and the sequencer state encoding.
package core_loader_pkg;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 28;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD_I = 4'd1;
  localparam logic [3:0] OP_LOAD_D = 4'd2;
  localparam logic [3:0] OP_RUN    = 4'd3;
  localparam logic [3:0] OP_STOP   = 4'd4;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetLen,
    StLoad,
    StGetBudget
  } state_e;

  function automatic logic [3:0] get_opcode(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/core_loader_run_timer.sv
// Run controller for the core: owns core_run, the cycle counter, the optional
// cycle budget and the expiry pulse.
module run_timer #(
  parameter int unsigned CYC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CYC_W-1:0] budget_i,
  output logic             core_run_o,
  output logic [CYC_W-1:0] cycles_o,
  output logic             done_o
);

  logic             run_q, run_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic [CYC_W-1:0] budget_q, budget_d;
  logic             done_q, done_d;
  logic [CYC_W-1:0] cycles_inc;
  logic             expire;

  assign cycles_inc = cycles_q + CYC_W'(1);
  // A zero budget means run until an explicit stop.
  assign expire = run_q && (budget_q != '0) && (cycles_inc == budget_q);

  always_comb begin
    run_d    = run_q;
    cycles_d = cycles_q;
    budget_d = budget_q;
    done_d   = 1'b0;
    if (run_q) begin
      cycles_d = cycles_inc;
    end
    if (start_i) begin
      run_d    = 1'b1;
      cycles_d = '0;
      budget_d = budget_i;
    end else if (stop_i || expire) begin
      run_d  = 1'b0;
      done_d = expire;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q    <= 1'b0;
      cycles_q <= '0;
      budget_q <= '0;
      done_q   <= 1'b0;
    end else begin
      run_q    <= run_d;
      cycles_q <= cycles_d;
      budget_q <= budget_d;
      done_q   <= done_d;
    end
  end

  assign core_run_o = run_q;
  assign cycles_o   = cycles_q;
  assign done_o     = done_q;

endmodule

// File: rtl/core_loader.sv
// Host-side sequencer: decodes a 32-bit command/data word stream, writes program
// and data images into the core memories and controls the core's run/reset.
module core_loader
  import core_loader_pkg::*;
#(
  parameter int unsigned CYC_W     = 32,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [31:0]      s_data_i,
  output logic             core_reset_o,
  output logic             core_run_o,
  output logic [31:0]      insn_addr_o,
  output logic [31:0]      insn_din_o,
  output logic             insn_we_o,
  output logic [31:0]      data_addr_o,
  output logic [31:0]      data_din_o,
  output logic             data_we_o,
  output logic [CYC_W-1:0] cycles_o,
  output logic             done_o,
  output logic             err_o
);

  state_e      state_q, state_d;
  logic        accept;
  logic [3:0]  opcode;
  logic        is_load_op;

  logic        target_d_q;
  logic [31:0] addr_q;
  logic [31:0] remain_q;
  logic        err_q;
  logic [31:0] insn_addr_q, insn_din_q, data_addr_q, data_din_q;

  logic        latch_target, latch_addr, latch_len, wr_en, set_err;
  logic        timer_start, timer_stop;

  assign s_ready_o  = rst_ni;
  assign accept     = s_valid_i & s_ready_o;
  assign opcode     = get_opcode(s_data_i);
  assign is_load_op = (opcode == OP_LOAD_I) || (opcode == OP_LOAD_D);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_load_op) begin
          state_d = StGetAddr;
        end else if (accept && (opcode == OP_RUN)) begin
          state_d = StGetBudget;
        end
      end
      StGetAddr: if (accept) state_d = StGetLen;
      StGetLen:  if (accept) state_d = (s_data_i == 32'd0) ? StIdle : StLoad;
      StLoad:    if (accept && (remain_q == 32'd1)) state_d = StIdle;
      StGetBudget: if (accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    latch_target = 1'b0;
    latch_addr   = 1'b0;
    latch_len    = 1'b0;
    wr_en        = 1'b0;
    set_err      = 1'b0;
    timer_start  = 1'b0;
    timer_stop   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (opcode)
            OP_LOAD_I, OP_LOAD_D: begin
              latch_target = 1'b1;
              // Never write memories under a running core.
              timer_stop   = 1'b1;
            end
            OP_STOP: timer_stop = 1'b1;
            OP_RUN, OP_NOP: ;
            default: set_err = 1'b1;
          endcase
        end
      end
      StGetAddr:   latch_addr  = accept;
      StGetLen:    latch_len   = accept;
      StLoad:      wr_en       = accept;
      StGetBudget: timer_start = accept;
      default: ;
    endcase
  end

  assign insn_we_o = wr_en & ~target_d_q;
  assign data_we_o = wr_en & target_d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_d_q  <= 1'b0;
      addr_q      <= '0;
      remain_q    <= '0;
      err_q       <= 1'b0;
      insn_addr_q <= '0;
      insn_din_q  <= '0;
      data_addr_q <= '0;
      data_din_q  <= '0;
    end else begin
      if (latch_target) target_d_q <= (opcode == OP_LOAD_D);
      if (latch_addr)   addr_q     <= s_data_i;
      if (latch_len)    remain_q   <= s_data_i;
      if (wr_en) begin
        addr_q   <= addr_q + 32'(ADDR_STEP);
        remain_q <= remain_q - 32'd1;
      end
      if (set_err) err_q <= 1'b1;
      if (insn_we_o) begin
        insn_addr_q <= addr_q;
        insn_din_q  <= s_data_i;
      end
      if (data_we_o) begin
        data_addr_q <= addr_q;
        data_din_q  <= s_data_i;
      end
    end
  end

  // Write ports show the live write while strobing, else the last one issued.
  assign insn_addr_o = insn_we_o ? addr_q   : insn_addr_q;
  assign insn_din_o  = insn_we_o ? s_data_i : insn_din_q;
  assign data_addr_o = data_we_o ? addr_q   : data_addr_q;
  assign data_din_o  = data_we_o ? s_data_i : data_din_q;
  assign err_o       = err_q;

  run_timer #(
    .CYC_W(CYC_W)
  ) u_run_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (timer_start),
    .stop_i     (timer_stop),
    .budget_i   (s_data_i[CYC_W-1:0]),
    .core_run_o (core_run_o),
    .cycles_o   (cycles_o),
    .done_o     (done_o)
  );

  assign core_reset_o = (state_q != StIdle) || !core_run_o;

endmodule
